// File: rtl/bus_fabric_pkg.sv
// Shared definitions for the cpu-to-slave bus fabric: FSM state encodings,
// the default error-response data word and the saturating error counter step.
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  localparam logic [15:0] DEFAULT_ERR_DATA = 16'hdead;
  localparam int          TIMER_W          = 8;
  localparam int          ERRCNT_W         = 8;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (v == {ERRCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bus_fabric_addr_match.sv
// Single address-window comparator: hit when the masked address equals the window base.
module bus_fabric_addr_match #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] mask_i,
  output logic              hit_o
);

  assign hit_o = ((addr_i & mask_i) == base_i);

endmodule

// File: rtl/bus_fabric.sv
// Memory-mapped interconnect from one cpu master to N_SLAVES slaves with
// parallel window decode, registered response and bus-error handling.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                          N_SLAVES = 4,
  parameter int                          ADDR_W   = 16,
  parameter int                          DATA_W   = 16,
  parameter logic [N_SLAVES*ADDR_W-1:0]  BASE     = {16'hffff, 16'hfffe, 16'h8000, 16'h0000},
  parameter logic [N_SLAVES*ADDR_W-1:0]  MASK     = {16'hffff, 16'hffff, 16'h8000, 16'h8000},
  parameter int                          TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]           ERR_DATA = DATA_W'(DEFAULT_ERR_DATA)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       read,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          data_out,
  output logic [DATA_W-1:0]          data_in,
  output logic                       ready,
  output logic [N_SLAVES-1:0]        s_read,
  output logic [N_SLAVES-1:0]        s_write,
  output logic [ADDR_W-1:0]          s_address,
  output logic [DATA_W-1:0]          s_data_out,
  input  logic [N_SLAVES*DATA_W-1:0] s_data_in,
  input  logic [N_SLAVES-1:0]        s_ready,
  output logic                       bus_error,
  output logic [ADDR_W-1:0]          error_address,
  output logic [ERRCNT_W-1:0]        error_count
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 is_write_q, is_write_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [DATA_W-1:0]    data_in_q, data_in_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;
  logic [ERRCNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [N_SLAVES-1:0]  hit;
  logic                 any_hit;
  logic [IDX_W-1:0]     hit_idx;
  logic [N_SLAVES-1:0]  sel;

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_match
    bus_fabric_addr_match #(.ADDR_W(ADDR_W)) u_match (
      .addr_i (address),
      .base_i (BASE[g*ADDR_W +: ADDR_W]),
      .mask_i (MASK[g*ADDR_W +: ADDR_W]),
      .hit_o  (hit[g])
    );
  end

  // Ascending scan so the highest matching index wins on overlapping windows.
  always_comb begin
    any_hit = |hit;
    hit_idx = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) begin
      sel[i] = (idx_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    timer_d    = timer_q;
    data_in_d  = data_in_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (read || write) begin
          if ((read && write) || !any_hit) begin
            err_addr_d = address;
            data_in_d  = ERR_DATA;
            err_cnt_d  = sat_inc(err_cnt_q);
            state_d    = ST_ERROR;
          end else begin
            idx_d      = hit_idx;
            addr_d     = address;
            wdata_d    = data_out;
            is_write_d = write;
            timer_d    = '0;
            state_d    = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (s_ready[idx_q]) begin
          data_in_d = is_write_q ? '0 : s_data_in[idx_q*DATA_W +: DATA_W];
          state_d   = ST_RESP;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          err_addr_d = addr_q;
          data_in_d  = ERR_DATA;
          err_cnt_d  = sat_inc(err_cnt_q);
          state_d    = ST_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      timer_q    <= '0;
      data_in_q  <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      timer_q    <= timer_d;
      data_in_q  <= data_in_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign s_read        = (state_q == ST_ACCESS && !is_write_q) ? sel : '0;
  assign s_write       = (state_q == ST_ACCESS &&  is_write_q) ? sel : '0;
  assign s_address     = addr_q;
  assign s_data_out    = wdata_q;
  assign data_in       = data_in_q;
  assign ready         = (state_q == ST_RESP) || (state_q == ST_ERROR);
  assign bus_error     = (state_q == ST_ERROR);
  assign error_address = err_addr_q;
  assign error_count   = err_cnt_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: slave0 window narrowed to 0x0000/0xc000, TIMEOUT=8.
module tb_bus_fabric;

  logic        clk = 1'b0;
  logic        reset, read, write;
  logic [15:0] address, data_out, data_in, s_address, s_data_out, error_address;
  logic        ready, bus_error;
  logic [3:0]  s_read, s_write, s_ready;
  logic [63:0] s_data_in;
  logic [7:0]  error_count;

  bus_fabric #(
    .N_SLAVES (4),
    .ADDR_W   (16),
    .DATA_W   (16),
    .BASE     ({16'hffff, 16'hfffe, 16'h8000, 16'h0000}),
    .MASK     ({16'hffff, 16'hffff, 16'h8000, 16'hc000}),
    .TIMEOUT  (8),
    .ERR_DATA (16'hdead)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .data_out      (data_out),
    .data_in       (data_in),
    .ready         (ready),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_address     (s_address),
    .s_data_out    (s_data_out),
    .s_data_in     (s_data_in),
    .s_ready       (s_ready),
    .bus_error     (bus_error),
    .error_address (error_address),
    .error_count   (error_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Response scoreboard: every ready pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready_queue_depth", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_data_in", {16'h0, data_in}, {16'h0, e.data});
        chk("resp_bus_error", {31'h0, bus_error}, {31'h0, e.err});
      end
    end
  end

  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wd, input int rslv, input int rdly,
                         input logic [15:0] sdata, input logic [3:0] noise,
                         input int exp_lat, input logic [7:0] exp_strb,
                         input logic [15:0] exp_data, input logic exp_err);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    read = rd; write = wr; address = addr; data_out = wd;
    exp_q.push_back('{data: exp_data, err: exp_err});
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    for (int c = 1; c <= exp_lat + 4 && lat == 0; c++) begin
      s_ready = noise;
      if (rslv >= 0 && c == rdly) s_ready[rslv] = 1'b1;
      s_data_in = {4{16'h0bad}};
      if (rslv >= 0) s_data_in[rslv*16 +: 16] = sdata;
      @(negedge clk);
      if (ready) begin
        lat = c;
        chk("strobes_low_on_ready", {24'h0, s_write, s_read}, 32'h0);
      end else begin
        chk("strobes", {24'h0, s_write, s_read}, {24'h0, exp_strb});
        if (c == 1) begin
          chk("s_address", {16'h0, s_address}, {16'h0, addr});
          if (wr) chk("s_data_out", {16'h0, s_data_out}, {16'h0, wd});
        end
      end
      @(posedge clk); #1;
    end
    s_ready = '0;
    chk("latency", 32'(lat), 32'(exp_lat));
    if (lat == 0 && exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int rdy_seen;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; data_out = '0;
    s_ready = '0; s_data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_in", {16'h0, data_in}, 32'h0);
    chk("rst_ready_err", {30'h0, ready, bus_error}, 32'h0);
    chk("rst_strobes", {24'h0, s_write, s_read}, 32'h0);
    chk("rst_s_bus", {s_address, s_data_out}, 32'h0);
    chk("rst_err_info", {8'h0, error_address, error_count}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // slave0 read, ready in T+3 -> response in T+4
    run_txn(1, 0, 16'h0010, 16'h0, 0, 3, 16'h1234, 4'b0000, 4, 8'h01, 16'h1234, 0);
    // overlap of slaves 1 and 2: slave2 wins; slave1 ready noise ignored
    run_txn(1, 0, 16'hfffe, 16'h0, 2, 2, 16'h00a5, 4'b0010, 3, 8'h04, 16'h00a5, 0);
    // slave1 write, ready in T+1 -> response in T+2, data_in 0
    run_txn(0, 1, 16'h8004, 16'hbeef, 1, 1, 16'h7777, 4'b0000, 2, 8'h20, 16'h0000, 0);
    // unmapped under narrowed slave0 window
    run_txn(1, 0, 16'h4000, 16'h0, -1, 0, 16'h0, 4'b0000, 1, 8'h00, 16'hdead, 1);
    chk("unmapped_err_addr", {16'h0, error_address}, 32'h4000);
    chk("unmapped_err_cnt", {24'h0, error_count}, 32'd1);
    repeat (3) @(negedge clk);
    chk("data_in_hold", {16'h0, data_in}, 32'hdead);
    // gpio (slave3)
    run_txn(1, 0, 16'hffff, 16'h0, 3, 1, 16'h5a5a, 4'b0000, 2, 8'h08, 16'h5a5a, 0);
    chk("err_addr_hold", {16'h0, error_address}, 32'h4000);
    chk("err_cnt_hold", {24'h0, error_count}, 32'd1);
    // timeout: strobe T+1..T+8, error at T+9
    run_txn(1, 0, 16'h0020, 16'h0, -1, 0, 16'h0, 4'b1110, 9, 8'h01, 16'hdead, 1);
    chk("timeout_err_addr", {16'h0, error_address}, 32'h0020);
    chk("timeout_err_cnt", {24'h0, error_count}, 32'd2);
    // read and write together
    run_txn(1, 1, 16'h8004, 16'h1111, 1, 1, 16'h2222, 4'b0000, 1, 8'h00, 16'hdead, 1);
    chk("conflict_err_addr", {16'h0, error_address}, 32'h8004);
    chk("conflict_err_cnt", {24'h0, error_count}, 32'd3);

    // reset in the middle of an ACCESS
    @(posedge clk); #1;
    read = 1'b1; address = 16'h0010;
    @(posedge clk); #1;
    read = 1'b0;
    @(negedge clk);
    chk("abort_pre_strobe", {28'h0, s_read}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_pre_reset_strobe", {28'h0, s_read}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("abort_strobes", {24'h0, s_write, s_read}, 32'h0);
    chk("abort_ready_err", {30'h0, ready, bus_error}, 32'h0);
    chk("abort_data_in", {16'h0, data_in}, 32'h0);
    chk("abort_err_info", {8'h0, error_address, error_count}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    s_ready = 4'b1111;
    rdy_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ready) rdy_seen++;
    end
    s_ready = '0;
    chk("abort_no_ready", 32'(rdy_seen), 32'd0);

    // error counter saturation
    for (int k = 1; k <= 257; k++) begin
      run_txn(1, 1, 16'(k), 16'h0, -1, 0, 16'h0, 4'b0000, 1, 8'h00, 16'hdead, 1);
      chk("sat_err_cnt", {24'h0, error_count}, (k > 255) ? 32'd255 : 32'(k));
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
